// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master write engine.
package i2c_pkg;

    localparam int   ADDR_W    = 7;
    localparam logic WRITE_BIT = 1'b0;
    localparam int   BIT_CNT   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

endpackage

// File: rtl/i2c_half_tick.sv
// SCL half-period timer: counts 0..HALF-1 and flags the last clock of each half.
module i2c_half_tick #(
    parameter int HALF = 250
) (
    input  logic i_Clock,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;

    // Held at zero while restart is asserted so the first phase after it is a full half.
    assign o_tick = (cnt == CW'(HALF - 1)) && !i_restart;

    // Free-running half counter, wrapping at every phase boundary.
    always_ff @(posedge i_Clock) begin
        if (i_reset || i_restart || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// I2C master write engine: START, address+W, data bytes from a byte source, STOP.
//
// state    | meaning
// IDLE     | bus released, waiting for i_start
// START    | SCL released, SDA pulled low (one half)
// ADDR     | shifting {addr, W}, two halves per bit
// ADDR_ACK | SDA released, i_sda sampled at end of high half
// DATA     | shifting the popped data byte
// DATA_ACK | SDA released, i_sda sampled at end of high half
// STOP     | three halves: SCL low/SDA low, SCL high/SDA low, SDA released
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLKS_PER_HALF_SCL = 250
) (
    input  logic              i_Clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    input  logic              i_data_valid,
    input  logic              i_sda,
    output logic              o_data_rd,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_nack,
    output logic              o_scl_oe,
    output logic              o_sda_oe
);

    state_t     state;
    logic       high_half;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       tick;

    i2c_half_tick #(
        .HALF (CLKS_PER_HALF_SCL)
    ) u_half_tick (
        .i_Clock   (i_Clock),
        .i_reset   (i_reset),
        .i_restart (state == IDLE),
        .o_tick    (tick)
    );

    // Sequencer: all line drives and strobes are registered and change only on phase boundaries.
    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            state     <= IDLE;
            high_half <= 1'b0;
            bit_idx   <= '0;
            shift     <= '0;
            o_data_rd <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_nack    <= 1'b0;
            o_scl_oe  <= 1'b0;
            o_sda_oe  <= 1'b0;
        end else begin
            o_data_rd <= 1'b0;
            o_done    <= 1'b0;
            case (state)
                IDLE: begin
                    o_scl_oe <= 1'b0;
                    o_sda_oe <= 1'b0;
                    if (i_start) begin
                        shift    <= {i_addr, WRITE_BIT};
                        o_nack   <= 1'b0;
                        o_busy   <= 1'b1;
                        o_sda_oe <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state     <= ADDR;
                        high_half <= 1'b0;
                        bit_idx   <= '0;
                        o_scl_oe  <= 1'b1;
                        o_sda_oe  <= ~shift[7];
                    end
                end
                ADDR, DATA: begin
                    if (tick) begin
                        if (!high_half) begin
                            high_half <= 1'b1;
                            o_scl_oe  <= 1'b0;
                        end else begin
                            high_half <= 1'b0;
                            o_scl_oe  <= 1'b1;
                            if (bit_idx == 3'(BIT_CNT - 1)) begin
                                o_sda_oe <= 1'b0;
                                state    <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                            end else begin
                                bit_idx  <= bit_idx + 1'b1;
                                shift    <= {shift[6:0], 1'b0};
                                o_sda_oe <= ~shift[6];
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (tick) begin
                        if (!high_half) begin
                            high_half <= 1'b1;
                            o_scl_oe  <= 1'b0;
                        end else begin
                            high_half <= 1'b0;
                            bit_idx   <= '0;
                            o_scl_oe  <= 1'b1;
                            if (i_sda) begin
                                o_nack   <= 1'b1;
                                o_sda_oe <= 1'b1;
                                state    <= STOP;
                            end else if (i_data_valid) begin
                                o_data_rd <= 1'b1;
                                shift     <= i_data;
                                o_sda_oe  <= ~i_data[7];
                                state     <= DATA;
                            end else begin
                                o_sda_oe <= 1'b1;
                                state    <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_idx == 3'd0) begin
                            bit_idx  <= 3'd1;
                            o_scl_oe <= 1'b0;
                        end else if (bit_idx == 3'd1) begin
                            bit_idx  <= 3'd2;
                            o_sda_oe <= 1'b0;
                        end else begin
                            bit_idx <= '0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: table of transactions, bus monitor with byte scoreboard, slave ACK model.
module tb_i2c_master_tx;

    localparam int H = 4;

    logic       i_Clock = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [6:0] i_addr;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       i_sda;
    logic       o_data_rd, o_busy, o_done, o_nack, o_scl_oe, o_sda_oe;

    always #5 i_Clock = ~i_Clock;

    i2c_master_tx #(
        .CLKS_PER_HALF_SCL (H)
    ) dut (
        .i_Clock      (i_Clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_sda        (i_sda),
        .o_data_rd    (o_data_rd),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_nack       (o_nack),
        .o_scl_oe     (o_scl_oe),
        .o_sda_oe     (o_sda_oe)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stimulus-side settings, written only by the main sequence.
    logic [6:0]      cur_addr  = 7'h00;
    int              nack_slot = -1;
    logic [2:0][7:0] src       = '0;
    int              src_n     = 0;
    int              pop_base  = 0;

    // Monitor / source state, written only by the negedge process.
    int         pops       = 0;
    int         bytes_seen = 0;
    logic       rd_prev    = 1'b0;
    logic       ps = 1'b0, pd = 1'b0;
    logic       in_frame   = 1'b0;
    logic       bit_seen   = 1'b0;
    int         m_bit      = 0;
    int         m_byte     = 0;
    logic [7:0] shreg      = '0;
    logic [7:0] exp_q[$];

    // Byte source, open-drain bus monitor with scoreboard, and ACK/NACK slave model.
    always @(negedge i_Clock) begin
        int k;
        logic [7:0] exp_b;
        if (o_data_rd) begin
            check("data_rd_one_cycle", int'(rd_prev), 0);
            k = pops - pop_base;
            if (k < src_n) exp_q.push_back(src[k]);
            pops++;
        end
        rd_prev = o_data_rd;
        k = pops - pop_base;
        i_data       = src[(k >= 0 && k < 3) ? k : 0];
        i_data_valid = (k < src_n);

        if (i_reset) begin
            in_frame = 1'b0;
        end else if (!ps && !o_scl_oe && !pd && o_sda_oe) begin
            in_frame = 1'b1;
            m_bit    = 0;
            m_byte   = 0;
            bit_seen = 1'b0;
            exp_q.delete();
            exp_q.push_back({cur_addr, 1'b0});
        end else if (!ps && !o_scl_oe && pd && !o_sda_oe) begin
            in_frame = 1'b0;
        end else if (in_frame) begin
            if (ps && !o_scl_oe) begin
                bit_seen = 1'b1;
                if (m_bit < 8) begin
                    shreg = {shreg[6:0], ~o_sda_oe};
                end else begin
                    check("ack_slot_sda_released", int'(o_sda_oe), 0);
                end
                if (m_bit == 7) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(shreg), -1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("sda_byte", int'(shreg), int'(exp_b));
                    end
                end
            end else if (!ps && o_scl_oe && bit_seen) begin
                bit_seen = 1'b0;
                if (m_bit == 8) begin
                    m_bit = 0;
                    m_byte++;
                end else begin
                    m_bit++;
                end
            end
        end
        ps = o_scl_oe;
        pd = o_sda_oe;
        i_sda = !(in_frame && m_bit == 8 && m_byte != nack_slot);
    end

    typedef struct {
        string           name;
        logic [6:0]      addr;
        int              n;
        logic [2:0][7:0] bytes;
        int              nack_slot;
        int              exp_pops;
        int              exp_nack;
        int              exp_bytes;
        int              exp_cycles;
    } vec_t;

    vec_t vecs[4];

    task automatic setup(input vec_t v);
        cur_addr  = v.addr;
        nack_slot = v.nack_slot;
        src       = v.bytes;
        src_n     = v.n;
        pop_base  = pops;
        i_addr    = v.addr;
    endtask

    task automatic accept(input string nm);
        @(negedge i_Clock);
        i_start = 1'b1;
        @(posedge i_Clock);
        #1;
        i_start = 1'b0;
        check({nm, "_busy_after_accept"}, int'(o_busy), 1);
        check({nm, "_nack_cleared"}, int'(o_nack), 0);
    endtask

    task automatic run_txn(input vec_t v);
        int n, p0, b0;
        logic seen;
        setup(v);
        p0 = pops;
        b0 = bytes_seen;
        accept(v.name);
        n = 0;
        seen = 1'b0;
        while (n < 2000 && !seen) begin
            @(posedge i_Clock);
            #1;
            n++;
            if (o_done) seen = 1'b1;
        end
        check({v.name, "_done_seen"}, int'(seen), 1);
        check({v.name, "_cycles"}, n, v.exp_cycles);
        check({v.name, "_pops"}, pops - p0, v.exp_pops);
        check({v.name, "_nack"}, int'(o_nack), v.exp_nack);
        check({v.name, "_bytes_on_sda"}, bytes_seen - b0, v.exp_bytes);
        check({v.name, "_scoreboard_empty"}, exp_q.size(), 0);
        check({v.name, "_idle_lines"}, int'({o_busy, o_scl_oe, o_sda_oe}), 0);
        @(posedge i_Clock);
        #1;
        check({v.name, "_done_one_cycle"}, int'(o_done), 0);
    endtask

    initial begin
        int n, p0, b0, dones, first_done;
        logic ok;

        vecs[0] = '{"one_byte",   7'h50, 1, {8'h00, 8'h00, 8'hA5}, -1, 1, 0, 2, 160};
        vecs[1] = '{"addr_nack",  7'h50, 1, {8'h00, 8'h00, 8'hA5},  0, 0, 1, 1, 88};
        vecs[2] = '{"three_byte", 7'h3C, 3, {8'h03, 8'h02, 8'h01}, -1, 3, 0, 4, 304};
        vecs[3] = '{"data_nack",  7'h12, 3, {8'h03, 8'h02, 8'h01},  2, 2, 1, 3, 232};

        // Reset with a start request present: nothing may happen.
        i_reset = 1'b1;
        i_start = 1'b1;
        i_addr  = 7'h50;
        repeat (5) @(posedge i_Clock);
        #1;
        check("reset_outputs", int'({o_data_rd, o_busy, o_done, o_nack, o_scl_oe, o_sda_oe}), 0);
        i_start = 1'b0;
        i_reset = 1'b0;
        repeat (3) @(posedge i_Clock);
        #1;
        check("post_reset_idle", int'({o_busy, o_scl_oe, o_sda_oe}), 0);

        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Extra starts while busy (one mid-frame, one on the final STOP edge) are ignored.
        setup(vecs[0]);
        p0 = pops;
        b0 = bytes_seen;
        accept("busy_start");
        dones = 0;
        first_done = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge i_Clock);
            #1;
            i_start = (c == 40 || c == 159);
            if (c == 40) i_addr = 7'h7F;
            if (o_done) begin
                dones++;
                if (first_done == 0) first_done = c;
            end
        end
        i_start = 1'b0;
        check("busy_start_done_count", dones, 1);
        check("busy_start_done_cycle", first_done, 160);
        check("busy_start_pops", pops - p0, 1);
        check("busy_start_bytes", bytes_seen - b0, 2);

        // Reset in the middle of the first data byte.
        setup(vecs[2]);
        p0 = pops;
        accept("mid_reset");
        n = 0;
        while (n < 500 && pops == p0) begin
            @(posedge i_Clock);
            #1;
            n++;
        end
        check("mid_reset_reached_data", int'(pops - p0 == 1), 1);
        repeat (10) @(posedge i_Clock);
        #1;
        check("mid_reset_busy_before", int'(o_busy), 1);
        i_reset = 1'b1;
        @(posedge i_Clock);
        #1;
        i_reset = 1'b0;
        check("mid_reset_released", int'({o_busy, o_nack, o_done, o_scl_oe, o_sda_oe}), 0);
        dones = 0;
        ok = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge i_Clock);
            #1;
            if (o_done) dones++;
            if (o_scl_oe || o_sda_oe || o_busy) ok = 1'b0;
        end
        check("mid_reset_no_stop_or_done", dones, 0);
        check("mid_reset_stays_idle", int'(ok), 1);

        run_txn(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_tx.md
# i2c_master_tx

I2C master write engine: issues START, a 7-bit address with the write bit, then data bytes popped from an upstream byte source (typically the FIFO fed by a UART receiver), then STOP. It is the initiator counterpart of the existing I2C slave receiver and forms the UART→I2C direction of the bridge. The SCL and SDA lines are driven open-drain through output-enable pins. The block runs entirely on the system clock.

## Interface
- CLKS_PER_HALF_SCL, 250, system clocks per SCL half-period (H); must be ≥2 (250 gives 100 kHz at 50 MHz)
- i_Clock  in  1  system clock; all logic on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request a transaction; honoured only in IDLE
- i_addr  in  7  target address; latched when i_start is accepted
- i_data  in  8  next byte to send; latched when o_data_rd pulses
- i_data_valid  in  1  a byte is available (e.g. inverted FIFO empty/underflow)
- i_sda  in  1  sampled SDA line level, used for ACK detection
- o_data_rd  out  1  one-cycle pop strobe, asserted in the cycle i_data is latched
- o_busy  out  1  high from the cycle after start acceptance until return to IDLE
- o_done  out  1  one-cycle pulse on return to IDLE
- o_nack  out  1  sticky; set on any NACK; cleared when the next i_start is accepted
- o_scl_oe  out  1  1 = pull SCL low; 0 = release
- o_sda_oe  out  1  1 = pull SDA low; 0 = release

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- Reset values: all outputs 0 (bus released, not busy); state IDLE; counters 0.
- **IDLE**
  - Both lines released.
  - If i_start=1: latch i_addr, clear o_nack, enter START.
- **START** (1 half-period): SCL released, SDA pulled low.
- **Bit slot** (2 half-periods, MSB first):
  - Low half: o_scl_oe=1, o_sda_oe=~bit.
  - High half: o_scl_oe=0, SDA held.
- **ADDR**: shifts {i_addr, 1'b0} (write).
- **ACK slot**
  - Same timing as a bit slot, with o_sda_oe=0.
  - i_sda is sampled on the last clock of the high half.
- **After an ACK slot**
  - i_sda=1 (NACK): set o_nack, go to STOP.
  - ACK and i_data_valid=1: pulse o_data_rd, latch i_data, go to DATA.
  - ACK and i_data_valid=0: go to STOP.
- **DATA**: shifts the latched byte, then DATA_ACK with the same decision rule as above.
- **STOP** (3 half-periods):
  - SCL low / SDA low.
  - SCL released / SDA low.
  - SDA released (bus free).
  - Then pulse o_done and enter IDLE.
- No clock stretching or arbitration; SCL is not monitored.
- Boundary conditions:
  - i_start while busy: ignored, no effect.
  - i_data_valid is sampled only at ACK-slot end; it is ignored elsewhere.
  - i_start in the same cycle as o_done: ignored; the block accepts it only once in IDLE.
  - Reset mid-transaction: next edge releases both lines, clears busy/nack, enters IDLE; no STOP is generated.

## Timing
- Half-period counter runs 0..H-1 and restarts at every phase boundary.
- Line changes take effect on the clock edge that starts a phase; o_scl_oe and o_sda_oe are registered.
- Within a bit slot, SDA changes only at the start of the low half.
- Transaction length for N data bytes with all ACKs: H·(4 + 18·(N+1)) cycles, measured from the start-accept edge to the o_done edge.
- Address NACK: H·22 cycles.
- o_data_rd is one cycle wide, at the first clock after the ACK slot ends. At most one pulse per byte.

## Structure
- Shared package `i2c_pkg` holds:
  - state encoding constants
  - ADDR_W=7
  - WRITE_BIT=1'b0
  - bit count 8
- Natural sub-module: `i2c_half_tick`, a half-period counter with restart input and end-of-half pulse.
- Top FSM, shift register and bit counter live in i2c_master_tx.

## Test plan
1. Reset with H=4 → all outputs 0; i_start asserted while i_reset=1 does nothing.
2. i_addr=0x50, i_data=0xA5, valid for one byte, slave ACKs every slot →
   - SDA bit sequence 1010_0000, ACK, 1010_0101, ACK
   - one o_data_rd pulse
   - o_done exactly 160 cycles after acceptance
   - o_nack=0
3. Address NACK (i_sda=1 in ADDR_ACK) →
   - no o_data_rd
   - STOP issued
   - o_nack=1
   - o_done at 88 cycles
4. Three bytes 0x01, 0x02, 0x03 with i_data_valid held high until the third pop, all ACK →
   - three o_data_rd pulses
   - bytes on SDA in order
   - o_done at 304 cycles
5. NACK on the second data byte of three →
   - two o_data_rd pulses
   - STOP right after the second byte's ACK slot
   - o_nack=1
   - o_nack clears on the next accepted i_start
6. Reset asserted mid-DATA →
   - next edge: o_scl_oe=o_sda_oe=o_busy=0
   - a second i_start issued during an active transaction is ignored, and o_done fires once for the original transaction only
